// File: rtl/siso_tx_scheduler.sv
// rtl/siso_tx_scheduler.sv - round-robin share of one MSB-first serial shifter among NREQ word requesters
// Grants a requester in IDLE, shifts its captured word out, then idles GAP cycles before re-arbitrating.
module siso_tx_scheduler #(
  parameter int SIZE = 8,
  parameter int NREQ = 4,
  parameter int GAP  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*SIZE-1:0]      data,
  output logic [NREQ-1:0]           ack,
  output logic                      ser_out,
  output logic                      ser_valid,
  output logic                      frame_start,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      done,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t            state_q;
  logic [IW-1:0]     rr_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [3:0]        gap_cnt_q;
  logic [SIZE-1:0]   shift_q;
  logic [NREQ-1:0]   ack_q;
  logic              ser_out_q;
  logic              ser_valid_q;
  logic              frame_start_q;
  logic [IW-1:0]     owner_q;
  logic              done_q;
  logic              busy_q;

  logic [IW-1:0]     grant_d;
  logic              grant_vld_d;
  logic [SIZE-1:0]   word_d;
  logic [NREQ-1:0]   ack_d;
  logic [IW-1:0]     cand;

  // Scan downward so the nearest set index after rr_q is the last one assigned.
  always_comb begin
    grant_d     = rr_q;
    grant_vld_d = 1'b0;
    cand        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(rr_q) + k >= NREQ) ? IW'(int'(rr_q) + k - NREQ) : IW'(int'(rr_q) + k);
      if (req[cand]) begin
        grant_d     = cand;
        grant_vld_d = 1'b1;
      end
    end
    word_d = '0;
    ack_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d == IW'(i)) begin
        word_d   = data[i*SIZE +: SIZE];
        ack_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_q          <= IW'(NREQ - 1);
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      shift_q       <= '0;
      ack_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      owner_q       <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // Pulse outputs drop on every edge, including stalled ones.
      ack_q         <= '0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      if (enable) begin
        case (state_q)
          ST_IDLE: begin
            if (grant_vld_d) begin
              shift_q       <= word_d;
              rr_q          <= grant_d;
              owner_q       <= grant_d;
              ack_q         <= ack_d;
              ser_out_q     <= word_d[SIZE-1];
              ser_valid_q   <= 1'b1;
              frame_start_q <= 1'b1;
              bit_cnt_q     <= '0;
              busy_q        <= 1'b1;
              state_q       <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (bit_cnt_q == BW'(SIZE - 1)) begin
              ser_valid_q <= 1'b0;
              ser_out_q   <= 1'b0;
              done_q      <= 1'b1;
              bit_cnt_q   <= '0;
              if (GAP == 0) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= ST_GAP;
                gap_cnt_q <= 4'(GAP);
              end
            end else begin
              shift_q   <= {shift_q[SIZE-2:0], 1'b0};
              ser_out_q <= shift_q[SIZE-2];
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
          ST_GAP: begin
            if (gap_cnt_q <= 4'd1) begin
              gap_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q - 4'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ack         = ack_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign owner       = owner_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_siso_tx_scheduler.sv
// tb/tb_siso_tx_scheduler.sv - directed bench for siso_tx_scheduler (GAP=1 and GAP=0 instances)
module tb_siso_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req, req_b;
  logic [31:0] data, data_b;
  logic [3:0]  ack, ack_b;
  logic        ser_out, ser_valid, frame_start, done, busy;
  logic        ser_out_b, ser_valid_b, frame_start_b, done_b, busy_b;
  logic [1:0]  owner, owner_b;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_dead;

  always #5 clk = ~clk;

  siso_tx_scheduler #(.SIZE(8), .NREQ(4), .GAP(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .data(data),
    .ack(ack), .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .owner(owner), .done(done), .busy(busy)
  );

  siso_tx_scheduler #(.SIZE(8), .NREQ(4), .GAP(0)) u_dut_g0 (
    .clk(clk), .reset(reset), .enable(enable), .req(req_b), .data(data_b),
    .ack(ack_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b), .frame_start(frame_start_b),
    .owner(owner_b), .done(done_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic valid_of(input int sel);
    return (sel != 0) ? ser_valid_b : ser_valid;
  endfunction

  task automatic tick_drop(input int sel);
    tick();
    if (sel != 0) req_b = req_b & ~ack_b;
    else          req   = req & ~ack;
  endtask

  // Waits for a grant, then follows the whole frame; stall_at >= 0 holds enable low for 5 cycles on that bit.
  task automatic run_frame(input int exp_g, input logic [7:0] exp_w, input int stall_at, input string tag);
    int cyc, nb, nfs, nack, ndone, nbusy_lo;
    logic [7:0] w;
    bit stalled;
    cyc = 0;
    while (ack == 4'b0 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_grant"}, onehot_idx(ack), exp_g);
    req = req & ~ack;
    check({tag, "_owner"}, owner, exp_g);
    w = '0; nb = 0; nfs = 0; nack = 0; ndone = 0; nbusy_lo = 0; cyc = 0; stalled = 1'b0;
    while (nb < 8 && cyc < 60) begin
      if (ser_valid && nb == stall_at && !stalled) begin
        enable = 1'b0;
        repeat (5) begin
          tick();
          check({tag, "_stall_bit"}, ser_out, exp_w[7-stall_at]);
          check({tag, "_stall_valid"}, ser_valid, 1);
          check({tag, "_stall_owner"}, owner, exp_g);
        end
        enable = 1'b1;
        stalled = 1'b1;
      end
      if (ser_valid) begin
        w = {w[6:0], ser_out};
        nb++;
        if (frame_start) nfs++;
      end
      if (cyc > 0 && ack != 4'b0) nack++;
      if (done) ndone++;
      if (!busy) nbusy_lo++;
      tick();
      cyc++;
    end
    check({tag, "_word"}, w, exp_w);
    check({tag, "_frame_start_cnt"}, nfs, 1);
    check({tag, "_extra_ack"}, nack, 0);
    check({tag, "_early_done"}, ndone, 0);
    check({tag, "_busy_gap"}, nbusy_lo, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_valid_end"}, ser_valid, 0);
    check({tag, "_busy_in_gap"}, busy, 1);
    tick();
    check({tag, "_done_once"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_owner_hold"}, owner, exp_g);
  endtask

  // Counts ser_valid=0 cycles between the last bit of one frame and the first bit of the next.
  task automatic count_dead(input int sel, output int n);
    int cyc;
    n = 0;
    cyc = 0;
    while (!valid_of(sel) && cyc < 40) begin tick_drop(sel); cyc++; end
    while (valid_of(sel) && cyc < 80) begin tick_drop(sel); cyc++; end
    while (!valid_of(sel) && cyc < 120) begin n++; tick_drop(sel); cyc++; end
    while (valid_of(sel) && cyc < 160) begin tick_drop(sel); cyc++; end
    tick_drop(sel);
    tick_drop(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    req = '0; data = '0; req_b = '0; data_b = '0;
    repeat (2) tick();
    check("rst_outputs", {ack, ser_out, ser_valid, frame_start, owner, done, busy}, 0);
    check("rst_outputs_g0", {ack_b, ser_out_b, ser_valid_b, frame_start_b, owner_b, done_b, busy_b}, 0);
    reset = 1'b0;
    tick();

    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    run_frame(0, 8'h11, -1, "rr0");
    run_frame(1, 8'h22, -1, "rr1");
    run_frame(2, 8'h33, -1, "rr2");
    run_frame(3, 8'h44, -1, "rr3");
    req = 4'b0101;
    run_frame(0, 8'h11, -1, "rr_b0");
    run_frame(2, 8'h33, -1, "rr_b2");

    data[7:0] = 8'hA5;
    req = 4'b0001;
    run_frame(0, 8'hA5, -1, "single");

    data[15:8]  = 8'h6C;
    data[31:24] = 8'h93;
    req = 4'b1010;
    count_dead(0, n_dead);
    check("gap1_dead", n_dead, 2);
    data_b = {8'h0F, 8'hF0, 8'h55, 8'hAA};
    req_b = 4'b1010;
    count_dead(1, n_dead);
    check("gap0_dead", n_dead, 1);

    data[7:0] = 8'h3C;
    req = 4'b0001;
    run_frame(0, 8'h3C, 3, "stall");

    data[23:16] = 8'hFF;
    req = 4'b0100;
    n_dead = 0;
    while (ack == 4'b0 && n_dead < 40) begin tick(); n_dead++; end
    check("mid_rst_grant", onehot_idx(ack), 2);
    req = 4'b0000;
    repeat (4) tick();
    check("mid_rst_bit4_valid", ser_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_async_clear", {ack, ser_out, ser_valid, frame_start, owner, done, busy}, 0);
    tick();
    check("mid_rst_held", {ack, ser_out, ser_valid, frame_start, owner, done, busy}, 0);
    reset = 1'b0;
    data[31:24] = 8'h81;
    req = 4'b1100;
    tick();
    check("mid_rst_no_done", done, 0);
    run_frame(2, 8'hFF, -1, "post_rst2");
    run_frame(3, 8'h81, -1, "post_rst3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
